// File: rtl/deser_pkg.sv
// Types and defaults for the frame deserializer: FSM state encoding and the
// default sync word and word width.
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0]  DESER_SYNC_DEFAULT  = 8'hA5;
  localparam int unsigned DESER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/frame_deserializer.sv
// Serial-to-word frame deserializer: hunts for SYNC_WORD, emits FRAME_WORDS words
// MSB first, re-checks sync after every frame. FRAME_DESER_ERRCNT_EN adds err_cnt.
module frame_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned     WIDTH       = DESER_WIDTH_DEFAULT,
  parameter int unsigned     FRAME_WORDS = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(DESER_SYNC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             locked,
  output logic             frame_err
`ifdef FRAME_DESER_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned WW = $clog2(FRAME_WORDS) + 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [WW-1:0] WORD_ONE  = WW'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WW-1:0]    word_cnt, word_cnt_n;
  logic [WIDTH-1:0] data_out_n;
  logic             data_valid_n, locked_n, frame_err_n;

  always_comb nxt = {shreg[WIDTH-2:0], bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= nxt;
      bit_cnt    <= bit_cnt_n;
      word_cnt   <= word_cnt_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      locked     <= locked_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    word_cnt_n   = word_cnt;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    locked_n     = locked;
    frame_err_n  = 1'b0;
    case (state)
      HUNT: begin
        if (nxt == SYNC_WORD) begin
          state_n    = DATA;
          locked_n   = 1'b1;
          bit_cnt_n  = '0;
          word_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          data_out_n   = nxt;
          data_valid_n = 1'b1;
          bit_cnt_n    = '0;
          word_cnt_n   = word_cnt + WORD_ONE;
          if (word_cnt == WORD_LAST) state_n = CHECK;
        end else begin
          bit_cnt_n = bit_cnt + BIT_ONE;
        end
      end
      CHECK: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_n = '0;
          if (nxt == SYNC_WORD) begin
            state_n    = DATA;
            word_cnt_n = '0;
          end else begin
            // shreg keeps the mismatched word so HUNT can find an overlapping sync
            state_n     = HUNT;
            locked_n    = 1'b0;
            frame_err_n = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + BIT_ONE;
        end
      end
      default: begin
        state_n    = HUNT;
        bit_cnt_n  = '0;
        word_cnt_n = '0;
        data_out_n = '0;
        locked_n   = 1'b0;
      end
    endcase
  end

`ifdef FRAME_DESER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_cnt <= '0;
    else if (frame_err_n && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench for frame_deserializer (WIDTH=8, FRAME_WORDS=2, SYNC=A5);
// stimulus queues expected words, a negedge monitor pops and compares them.
module tb_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       frame_err;
`ifdef FRAME_DESER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int exp_errs  = 0;
  int seen_errs = 0;

  frame_deserializer #(
    .WIDTH      (8),
    .FRAME_WORDS(2),
    .SYNC_WORD  (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked),
    .frame_err (frame_err)
`ifdef FRAME_DESER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every data_valid pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (data_valid || frame_err)
      chk("valid_err_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_out=%0h expected no pulse", data_out);
      end else begin
        chk("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (frame_err) seen_errs++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] sync;
    sync   = 8'hA5;
    bit_in = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
`ifdef FRAME_DESER_ERRCNT_EN
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    rst = 1'b0;

    // 1: lock on A5 exactly after its 8th bit; two words; sync word not emitted
    for (int i = 7; i >= 1; i--) send_bit(sync[i]);
    chk("t1_not_locked_7bits", {31'd0, locked}, 32'd0);
    send_bit(sync[0]);
    chk("t1_locked_8bits", {31'd0, locked}, 32'd1);
    send_word(8'h3C);
    chk("t1_latency_valid", {31'd0, data_valid}, 32'd1);
    chk("t1_latency_data", {24'd0, data_out}, 32'h3C);
    send_word(8'hC3);
    send_byte(8'hA5);
    chk("t1_locked_after_check", {31'd0, locked}, 32'd1);
    chk("t1_no_valid_on_sync", {31'd0, data_valid}, 32'd0);

    // 2: noise 1,1,0 then A5 5A 81
    do_reset();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_byte(8'hA5);
    chk("t2_locked", {31'd0, locked}, 32'd1);
    send_word(8'h5A);
    send_word(8'h81);

    // 3: bad sync word at frame end
    exp_errs++;
    send_byte(8'h00);
    chk("t3_frame_err", {31'd0, frame_err}, 32'd1);
    chk("t3_unlocked", {31'd0, locked}, 32'd0);
    chk("t3_no_valid", {31'd0, data_valid}, 32'd0);

    // 4: relock from the mismatched word still in the shifter
    send_byte(8'hA5);
    chk("t4_relocked", {31'd0, locked}, 32'd1);
    send_word(8'h11);
    send_word(8'h22);
    send_byte(8'hA5);
    chk("t4_data_held", {24'd0, data_out}, 32'h22);
    chk("t4_no_valid_sync", {31'd0, data_valid}, 32'd0);
    chk("t4_still_locked", {31'd0, locked}, 32'd1);

    // 5: async reset 5 bits into a data word
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_data_out", {24'd0, data_out}, 32'd0);
    chk("t5_async_locked", {31'd0, locked}, 32'd0);
    chk("t5_async_valid", {31'd0, data_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'hA5);
    chk("t5_relocked", {31'd0, locked}, 32'd1);
    send_word(8'h77);
    send_word(8'h88);
    send_byte(8'hA5);

`ifdef FRAME_DESER_ERRCNT_EN
    // 6: error counter and saturation
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send_byte(8'hA5);
      send_word(8'h00);
      send_word(8'h00);
      exp_errs++;
      send_byte(8'h00);
      if (n == 2) chk("t6_err_cnt_3", {24'd0, err_cnt}, 32'd3);
    end
    chk("t6_err_cnt_sat", {24'd0, err_cnt}, 32'hFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("frame_err_pulses", seen_errs, exp_errs);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
